// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response bus between the IF-stage fetch controller
// (master) and instruction memory (slave). One outstanding request at a time.
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// IF-stage PC sequencer: one-outstanding imem fetch, 2-entry {instr,pc} queue to decode,
// redirect handling with stale-response drop. Optional macro PC_MISALIGN_TRAP_EN.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [1:0]      i_PCSrc,
  input  logic            i_exception,
  input  logic [31:0]     i_brTarget,
  input  logic [31:0]     i_jalrTarget,
  input  logic [31:0]     i_mtvec,
  input  logic [31:0]     i_mepc,
  input  logic            i_stall,
  pc_fetch_ctrl_if.master imem,
  output logic            o_instr_valid,
  output logic [31:0]     o_instr,
  output logic [31:0]     o_pc,
  output logic            o_flush
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic            o_misalign,
  output logic [31:0]     o_badaddr
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] instr0_q, instr0_d, instr1_q, instr1_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [1:0]  count_q, count_d;

  logic        flush_s;
  logic        req_s;
  logic        push_s;
  logic        pop_s;
  logic [1:0]  slot_s;
  logic [31:0] target_s;
  logic [31:0] redirect_pc_s;
  logic        unused_jalr_lsb_s;

`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_s;
  logic        misalign_q, misalign_d;
  logic [31:0] badaddr_q, badaddr_d;
`endif

  assign unused_jalr_lsb_s = i_jalrTarget[0];

  // Redirect target selected by the EX-stage PC-source code
  always_comb begin
    target_s = fetch_pc_q;
    case (i_PCSrc)
      2'b01:   target_s = i_brTarget;
      2'b10:   target_s = i_exception ? i_mtvec : i_mepc;
      2'b11:   target_s = {i_jalrTarget[31:1], 1'b0};
      default: target_s = fetch_pc_q;
    endcase
  end

  assign flush_s = |i_PCSrc;

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_s    = flush_s && (target_s[1:0] != 2'b00);
  assign redirect_pc_s = misalign_s ? i_mtvec : target_s;
`else
  assign redirect_pc_s = target_s;
`endif

  // Occupancy gating guarantees the single in-flight response always finds a free slot
  assign req_s  = (state_q == ST_FETCH) && !inflight_q && (count_q < 2'd2) && !flush_s;
  assign push_s = (state_q == ST_FETCH) && inflight_q && imem.imem_rvalid && !flush_s;
  assign pop_s  = (count_q != 2'd0) && !i_stall && !flush_s;
  assign slot_s = count_q - {1'b0, pop_s};

  // Sequencer next state: fetch PC, in-flight tracking, stale-response drop
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    case (state_q)
      ST_BOOT: begin
        state_d    = ST_FETCH;
        fetch_pc_d = flush_s ? redirect_pc_s : fetch_pc_q;
      end
      ST_FETCH: begin
        if (flush_s) begin
          fetch_pc_d = redirect_pc_s;
          if (inflight_q && !imem.imem_rvalid) begin
            state_d    = ST_DROP;
            inflight_d = 1'b1;
          end else begin
            state_d    = ST_FETCH;
            inflight_d = 1'b0;
          end
        end else if (req_s && imem.imem_gnt) begin
          inflight_d    = 1'b1;
          inflight_pc_d = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + 32'd4;
        end else if (push_s) begin
          inflight_d = 1'b0;
        end else begin
          inflight_d = inflight_q;
        end
      end
      ST_DROP: begin
        fetch_pc_d = flush_s ? redirect_pc_s : fetch_pc_q;
        if (imem.imem_rvalid) begin
          inflight_d = 1'b0;
          state_d    = ST_FETCH;
        end else begin
          inflight_d = inflight_q;
          state_d    = ST_DROP;
        end
      end
      default: begin
        state_d    = ST_BOOT;
        inflight_d = 1'b0;
      end
    endcase
  end

  // Two-entry queue; entry 0 is always the head presented to decode
  always_comb begin
    instr0_d = instr0_q;
    instr1_d = instr1_q;
    pc0_d    = pc0_q;
    pc1_d    = pc1_q;
    if (flush_s) begin
      count_d = 2'd0;
    end else begin
      count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
    end
    if (pop_s) begin
      instr0_d = instr1_q;
      pc0_d    = pc1_q;
    end else begin
      instr0_d = instr0_q;
      pc0_d    = pc0_q;
    end
    if (push_s) begin
      if (slot_s == 2'd0) begin
        instr0_d = imem.imem_rdata;
        pc0_d    = inflight_pc_q;
      end else begin
        instr1_d = imem.imem_rdata;
        pc1_d    = inflight_pc_q;
      end
    end else begin
      instr1_d = instr1_q;
      pc1_d    = pc1_q;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Misaligned redirect capture: one-cycle flag, address held until the next one
  always_comb begin
    misalign_d = misalign_s;
    if (misalign_s) begin
      badaddr_d = target_s;
    end else begin
      badaddr_d = badaddr_q;
    end
  end
`endif

  // State registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_BOOT;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      instr0_q      <= 32'd0;
      instr1_q      <= 32'd0;
      pc0_q         <= 32'd0;
      pc1_q         <= 32'd0;
      count_q       <= 2'd0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q    <= 1'b0;
      badaddr_q     <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      instr0_q      <= instr0_d;
      instr1_q      <= instr1_d;
      pc0_q         <= pc0_d;
      pc1_q         <= pc1_d;
      count_q       <= count_d;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q    <= misalign_d;
      badaddr_q     <= badaddr_d;
`endif
    end
  end

  assign imem.imem_req  = req_s;
  assign imem.imem_addr = fetch_pc_q;
  assign o_instr_valid  = (count_q != 2'd0);
  assign o_instr        = instr0_q;
  assign o_pc           = pc0_q;
  assign o_flush        = flush_s;
`ifdef PC_MISALIGN_TRAP_EN
  assign o_misalign     = misalign_q;
  assign o_badaddr      = badaddr_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed steps then randomized traffic, checked against an
// in-order instruction-stream model (expected next PC, per-address instruction pattern).
module tb_pc_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        i_clk;
  logic        i_rst_n;
  logic [1:0]  i_PCSrc;
  logic        i_exception;
  logic [31:0] i_brTarget;
  logic [31:0] i_jalrTarget;
  logic [31:0] i_mtvec;
  logic [31:0] i_mepc;
  logic        i_stall;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_flush;
`ifdef PC_MISALIGN_TRAP_EN
  logic        o_misalign;
  logic [31:0] o_badaddr;
`endif

  pc_fetch_ctrl_if imem_if ();

  pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_PCSrc      (i_PCSrc),
    .i_exception  (i_exception),
    .i_brTarget   (i_brTarget),
    .i_jalrTarget (i_jalrTarget),
    .i_mtvec      (i_mtvec),
    .i_mepc       (i_mepc),
    .i_stall      (i_stall),
    .imem         (imem_if),
    .o_instr_valid(o_instr_valid),
    .o_instr      (o_instr),
    .o_pc         (o_pc),
    .o_flush      (o_flush)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .o_misalign   (o_misalign),
    .o_badaddr    (o_badaddr)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          n_checks;
  int          n_errors;
  int          cyc;
  int          pops;
  int          mem_lat;
  bit          gnt_rand;
  logic [31:0] exp_pc;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic        acc_r;
  logic [31:0] acc_addr_r;
  logic        prev_wait_r;
  logic [31:0] prev_addr_r;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] model_target();
    logic [31:0] t;
    case (i_PCSrc)
      2'b01:   t = i_brTarget;
      2'b11:   t = i_jalrTarget & 32'hFFFF_FFFE;
      default: t = i_exception ? i_mtvec : i_mepc;
    endcase
`ifdef PC_MISALIGN_TRAP_EN
    if (t[1:0] != 2'b00) t = i_mtvec;
`endif
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample outputs late in the cycle, then play memory after the edge
  task automatic tick();
    #3;
    acc_r      = imem_if.imem_req && imem_if.imem_gnt;
    acc_addr_r = imem_if.imem_addr;
    check("flush_comb", {31'd0, o_flush}, {31'd0, |i_PCSrc});
    if (prev_wait_r && imem_if.imem_req) check("addr_hold", imem_if.imem_addr, prev_addr_r);
    prev_wait_r = imem_if.imem_req && !imem_if.imem_gnt;
    prev_addr_r = imem_if.imem_addr;
    if (|i_PCSrc) begin
      exp_pc = model_target();
    end else if (o_instr_valid && !i_stall) begin
      check("pop_pc", o_pc, exp_pc);
      check("pop_instr", o_instr, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    @(posedge i_clk);
    #1;
    cyc++;
    if (acc_r) begin
      pend_addr.push_back(acc_addr_r);
      pend_due.push_back(cyc - 1 + mem_lat);
    end
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_if.imem_rvalid = 1'b1;
      imem_if.imem_rdata  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_if.imem_rvalid = 1'b0;
      imem_if.imem_rdata  = 32'hDEAD_BEEF;
    end
    imem_if.imem_gnt = gnt_rand ? ($urandom_range(0, 3) != 32'd0) : 1'b1;
    #1;
  endtask

  task automatic redirect(input logic [1:0] src, input logic exc, input logic [31:0] tgt);
    i_PCSrc      = src;
    i_exception  = exc;
    i_brTarget   = tgt;
    i_jalrTarget = tgt;
    #1;
    check("flush_on", {31'd0, o_flush}, 32'd1);
    check("req_gated_by_flush", {31'd0, imem_if.imem_req}, 32'd0);
    tick();
    i_PCSrc     = 2'b00;
    i_exception = 1'b0;
  endtask

  task automatic wait_accept(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    tick();
    while (!acc_r && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, {31'd0, acc_r}, 32'd1);
    if (acc_r) check(tag, acc_addr_r, exp);
  endtask

  initial begin
    logic [31:0] r;
    n_checks = 0; n_errors = 0; cyc = 0; pops = 0;
    mem_lat = 1; gnt_rand = 1'b0; exp_pc = RST_PC;
    acc_r = 1'b0; acc_addr_r = 32'd0; prev_wait_r = 1'b0; prev_addr_r = 32'd0;
    i_rst_n = 1'b0; i_PCSrc = 2'b00; i_exception = 1'b0;
    i_brTarget = 32'd0; i_jalrTarget = 32'd0; i_mtvec = 32'd0; i_mepc = 32'd0; i_stall = 1'b0;
    imem_if.imem_gnt = 1'b1; imem_if.imem_rvalid = 1'b0; imem_if.imem_rdata = 32'd0;

    repeat (3) @(posedge i_clk);
    #2;
    check("rst_req", {31'd0, imem_if.imem_req}, 32'd0);
    check("rst_addr", imem_if.imem_addr, RST_PC);
    check("rst_valid", {31'd0, o_instr_valid}, 32'd0);
    check("rst_instr", o_instr, 32'd0);
    check("rst_pc", o_pc, 32'd0);
    check("rst_flush", {31'd0, o_flush}, 32'd0);

    // Cycle 0 is BOOT; first request in cycle 1
    i_rst_n = 1'b1;
    #1;
    check("boot_no_req", {31'd0, imem_if.imem_req}, 32'd0);
    tick();
    check("c1_req", {31'd0, imem_if.imem_req}, 32'd1);
    check("c1_addr", imem_if.imem_addr, 32'h0000_0100);
    tick();
    check("c2_req_busy", {31'd0, imem_if.imem_req}, 32'd0);
    check("c2_valid", {31'd0, o_instr_valid}, 32'd0);
    tick();
    check("c3_valid", {31'd0, o_instr_valid}, 32'd1);
    check("c3_pc", o_pc, 32'h0000_0100);
    check("c3_instr", o_instr, mem_word(32'h0000_0100));
    check("c3_addr", imem_if.imem_addr, 32'h0000_0104);

    // Stall for six cycles from the first valid cycle
    i_stall = 1'b1;
    repeat (5) tick();
    check("stall_req_off", {31'd0, imem_if.imem_req}, 32'd0);
    check("stall_valid", {31'd0, o_instr_valid}, 32'd1);
    check("stall_pc_hold", o_pc, 32'h0000_0100);
    check("stall_instr_hold", o_instr, mem_word(32'h0000_0100));
    tick();
    i_stall = 1'b0;
    tick();
    check("unstall_pc", o_pc, 32'h0000_0104);
    check("unstall_req", {31'd0, imem_if.imem_req}, 32'd1);
    check("unstall_addr", imem_if.imem_addr, 32'h0000_0108);
    tick();

    // Branch while a request is in flight, response two cycles after grant
    mem_lat = 2;
    begin
      int n;
      n = 0;
      tick();
      while (!acc_r && n < 20) begin
        tick();
        n++;
      end
      check("br_setup_grant", {31'd0, acc_r}, 32'd1);
    end
    redirect(2'b01, 1'b0, 32'h0000_0200);
    check("br_flush_one_cycle", {31'd0, o_flush}, 32'd0);
    check("br_drop_no_req", {31'd0, imem_if.imem_req}, 32'd0);
    check("br_queue_cleared", {31'd0, o_instr_valid}, 32'd0);
    tick();
    check("br_req", {31'd0, imem_if.imem_req}, 32'd1);
    check("br_addr", imem_if.imem_addr, 32'h0000_0200);
    mem_lat = 1;

    i_mtvec = 32'h0000_0080;
    i_mepc  = 32'h0000_0300;
    redirect(2'b10, 1'b1, 32'd0);
    wait_accept("trap_mtvec", 32'h0000_0080);
    redirect(2'b10, 1'b0, 32'd0);
    wait_accept("mret_mepc", 32'h0000_0300);
    redirect(2'b11, 1'b0, 32'h0000_0401);
    wait_accept("jalr_lsb_clear", 32'h0000_0400);
    redirect(2'b01, 1'b0, 32'hFFFF_FFFC);
    wait_accept("wrap_top", 32'hFFFF_FFFC);
    wait_accept("wrap_zero", 32'h0000_0000);

    redirect(2'b01, 1'b0, 32'h0000_0202);
`ifdef PC_MISALIGN_TRAP_EN
    check("misalign_pulse", {31'd0, o_misalign}, 32'd1);
    check("misalign_badaddr", o_badaddr, 32'h0000_0202);
    wait_accept("misalign_to_mtvec", 32'h0000_0080);
    check("misalign_badaddr_held", o_badaddr, 32'h0000_0202);
`else
    wait_accept("unaligned_passthru", 32'h0000_0202);
`endif

    // Randomized traffic against the stream model
    gnt_rand = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      i_stall = ($urandom_range(0, 3) == 32'd0);
      mem_lat = $urandom_range(1, 3);
      if ($urandom_range(0, 15) == 32'd0) begin
        i_PCSrc      = 2'($urandom_range(1, 3));
        i_exception  = 1'($urandom_range(0, 1));
        r = $urandom; i_brTarget   = {r[31:2], 2'b00};
        r = $urandom; i_jalrTarget = {r[31:2], 1'b0, r[0]};
        r = $urandom; i_mtvec      = {r[31:2], 2'b00};
        r = $urandom; i_mepc       = {r[31:2], 2'b00};
      end else begin
        i_PCSrc = 2'b00;
      end
      tick();
    end
    i_PCSrc = 2'b00;
    i_stall = 1'b0;
    gnt_rand = 1'b0;
    repeat (10) tick();
    check("random_progress", {31'd0, (pops >= 200)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter sequencer and instruction-fetch controller for the core's IF stage. Owns the PC register, issues one-outstanding requests to instruction memory, and buffers returned instructions in a 2-entry queue toward decode. Applies redirects selected by the EX-stage 2-bit PC-source code: branch, jalr, trap/mret. Discards any in-flight response made stale by a redirect.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_PCSrc  in  2  00 PC+4, 01 taken branch, 10 exception or mret, 11 jalr
- i_exception  in  1  trap pending; selects mtvec when i_PCSrc=10
- i_brTarget  in  32  branch target (PC+imm from EX)
- i_jalrTarget  in  32  jalr target (rs1+imm from EX)
- i_mtvec  in  32  trap vector
- i_mepc  in  32  mret return address
- i_stall  in  1  decode cannot accept this cycle
- o_imem_req  out  1  fetch request valid
- o_imem_addr  out  32  fetch address
- i_imem_gnt  in  1  request accepted this cycle
- i_imem_rvalid  in  1  response valid; arrives ≥1 cycle after grant
- i_imem_rdata  in  32  response instruction
- o_instr_valid  out  1  queue head valid
- o_instr  out  32  queue head instruction
- o_pc  out  32  queue head PC
- o_flush  out  1  redirect this cycle; combinational, equals |i_PCSrc

## Operation
- States: BOOT, FETCH, DROP. Reset → BOOT; BOOT → FETCH unconditionally next cycle.
- Registers: fetch_pc (next address to request), inflight (1 bit), inflight_pc, 2-entry FIFO {instr, pc}, count 0..2.
- Redirect target: 01 → i_brTarget; 11 → {i_jalrTarget[31:1],1'b0}; 10 → i_exception ? i_mtvec : i_mepc (exception wins over mret).
- Request rule (FETCH): o_imem_req = !inflight && (count + 0) < 2 && !o_flush; o_imem_addr = fetch_pc. On req&gnt: inflight←1, inflight_pc←fetch_pc, fetch_pc←fetch_pc+4 (mod 2^32, wraps silently).
- Issue is gated by occupancy, so an arriving response always has a free slot even if i_stall rose after grant.
- Response (FETCH): rvalid → push {i_imem_rdata, inflight_pc}, inflight←0.
- Dequeue: o_instr_valid = count≠0; pop when o_instr_valid && !i_stall && !o_flush. Push and pop same cycle keep count.
- Redirect (o_flush=1), highest priority over stall: FIFO cleared (count←0), fetch_pc←target, no request that cycle. If inflight and rvalid not in the same cycle → DROP; else inflight←0, stay FETCH.
- DROP: o_imem_req=0; on rvalid data discarded, inflight←0, → FETCH. Redirect in DROP only updates fetch_pc; stays DROP.
- Redirect in BOOT: fetch_pc←target, still → FETCH.
- rvalid without inflight is a protocol error; ignored.

## Timing
- Reset values: o_imem_req=0, o_imem_addr=RESET_PC, o_instr_valid=0, o_instr=0, o_pc=0, fetch_pc=RESET_PC, count=0, inflight=0, state BOOT. o_flush follows i_PCSrc.
- Reset mid-transaction: all state cleared immediately; a later rvalid for the old request is ignored (inflight=0).
- First request: cycle 1 after reset release (BOOT occupies cycle 0).
- Redirect in cycle N with nothing inflight: o_imem_req=1, o_imem_addr=target in N+1.
- Zero-wait memory (gnt same cycle, rvalid next): sustained one instruction per 2 cycles; response to fetch granted in N is visible on o_instr_valid in N+2.
- o_imem_addr stable while o_imem_req=1 and i_imem_gnt=0.

## Configuration
- PC_MISALIGN_TRAP_EN defined: redirect target with bits[1:0]≠00 is not fetched; adds outputs o_misalign (1-cycle pulse in N+1) and o_badaddr (32, the target, held until next misalign); fetch_pc←i_mtvec instead.
- Undefined: no extra ports; target used as-is (jalr bit0 still cleared), bit1 propagates to o_imem_addr.

## Test plan
- Reset, RESET_PC=32'h100, gnt=1 always, rvalid 1 cycle later → addresses 100,104,108; o_pc sequence matches, o_instr_valid first high cycle 3.
- Hold i_stall=1 for 6 cycles from first valid → count saturates at 2, o_imem_req=0, o_instr/o_pc hold 100; release → 104,108 pop in order, no loss.
- Branch i_PCSrc=01, i_brTarget=32'h200 while request inflight, rvalid 2 cycles later → response dropped, next request 200, o_flush high exactly one cycle.
- i_PCSrc=10 with i_exception=1, mtvec=32'h80, mepc=32'h300 → fetch 80; same with i_exception=0 → fetch 300.
- jalr i_jalrTarget=32'h401 → fetch 400; fetch_pc at 32'hFFFF_FFFC wraps to 0.
- With PC_MISALIGN_TRAP_EN, branch target 32'h202 → o_misalign pulse, o_badaddr=202, next fetch at i_mtvec.
